// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle fetch/decode/execute controller that drives the
// program-counter select code (PS) and operand (PC_IN). It handles the
// instruction-memory handshake, resolves LEGv8-style branches against the ALU
// flags and stalls on multi-cycle datapath operations.
module pc_sequencer #(
   parameter int WAIT_LIMIT = 16,
   parameter int OFFSET_W   = 32
) (
   input  logic                clock,
   input  logic                reset,
   output logic                imem_req,
   input  logic                imem_ack,
   input  logic [31:0]         instr,
   input  logic [3:0]          status,
   input  logic                reg_zero,
   input  logic [31:0]         reg_data,
   input  logic                exec_done,
   output logic                exec_en,
   output logic [31:0]         ir,
   output logic [1:0]          PS,
   output logic [OFFSET_W-1:0] PC_IN,
   output logic                halted,
   output logic                fault
);

   localparam int          CNT_W     = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);
   localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

   localparam logic [1:0]  PS_HOLD = 2'b00;
   localparam logic [1:0]  PS_INC  = 2'b01;
   localparam logic [1:0]  PS_LOAD = 2'b10;
   localparam logic [1:0]  PS_ADD  = 2'b11;

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_UPDATE, S_HALT, S_FAULT
   } state_t;

   typedef enum logic [2:0] {
      K_ALU, K_B, K_BCOND, K_CBZ, K_CBNZ, K_BR
   } kind_t;

   state_t           state;
   kind_t            kind;
   logic [CNT_W-1:0] wait_cnt;

   // Instruction class of a (non-HALT) word.
   function automatic kind_t classify(input logic [31:0] word);
      kind_t k;
      k = K_ALU;
      if (word[31:26] == 6'b000101)          k = K_B;
      else if (word[31:24] == 8'b01010100)   k = K_BCOND;
      else if (word[31:24] == 8'b10110100)   k = K_CBZ;
      else if (word[31:24] == 8'b10110101)   k = K_CBNZ;
      else if (word[31:21] == 11'b11010110000) k = K_BR;
      return k;
   endfunction

   // B.cond condition evaluation; flags are {N, Z, C, V}.
   function automatic logic cond_met(input logic [3:0] cond, input logic [3:0] flags);
      logic n, z, c, v, r;
      n = flags[3];
      z = flags[2];
      c = flags[1];
      v = flags[0];
      case (cond)
         4'h0:    r = z;
         4'h1:    r = !z;
         4'h2:    r = c;
         4'h3:    r = !c;
         4'h4:    r = n;
         4'h5:    r = !n;
         4'h6:    r = v;
         4'h7:    r = !v;
         4'h8:    r = c & !z;
         4'h9:    r = !c | z;
         4'hA:    r = (n == v);
         4'hB:    r = (n != v);
         4'hC:    r = !z & (n == v);
         4'hD:    r = z | (n != v);
         default: r = 1'b1;
      endcase
      return r;
   endfunction

   // Taken decision for a branch class.
   function automatic logic branch_taken(input kind_t k, input logic [31:0] word,
                                         input logic [3:0] flags, input logic rz);
      logic t;
      case (k)
         K_B:     t = 1'b1;
         K_BR:    t = 1'b1;
         K_CBZ:   t = rz;
         K_CBNZ:  t = !rz;
         K_BCOND: t = cond_met(word[3:0], flags);
         default: t = 1'b0;
      endcase
      return t;
   endfunction

   // Word offset of a relative branch, sign-extended to the PC operand width.
   function automatic logic [OFFSET_W-1:0] branch_offset(input kind_t k, input logic [31:0] word);
      logic signed [25:0] off_b;
      logic signed [18:0] off_c;
      logic [OFFSET_W-1:0] r;
      off_b = word[25:0];
      off_c = word[23:5];
      if (k == K_B) r = OFFSET_W'(off_b);
      else          r = OFFSET_W'(off_c);
      return r;
   endfunction

   // Sequencer FSM with all outputs registered alongside the state.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state    <= S_FETCH;
         kind     <= K_ALU;
         wait_cnt <= '0;
         PS       <= PS_HOLD;
         PC_IN    <= '0;
         ir       <= '0;
         imem_req <= 1'b0;
         exec_en  <= 1'b0;
         halted   <= 1'b0;
         fault    <= 1'b0;
      end else begin
         case (state)
            S_FETCH: begin
               // First cycle out of reset only raises the request; an ack
               // counts once the request is visible to memory.
               if (!imem_req) begin
                  imem_req <= 1'b1;
               end else if (imem_ack) begin
                  ir       <= instr;
                  wait_cnt <= '0;
                  imem_req <= 1'b0;
                  state    <= S_DECODE;
               end else if (wait_cnt == CNT_LAST) begin
                  imem_req <= 1'b0;
                  fault    <= 1'b1;
                  state    <= S_FAULT;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_DECODE: begin
               if (ir == HALT_WORD) begin
                  halted <= 1'b1;
                  state  <= S_HALT;
               end else begin
                  kind    <= classify(ir);
                  exec_en <= (classify(ir) == K_ALU);
                  state   <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (kind == K_ALU) begin
                  if (exec_done) begin
                     exec_en <= 1'b0;
                     PS      <= PS_INC;
                     PC_IN   <= '0;
                     state   <= S_UPDATE;
                  end
               end else begin
                  // Branches resolve in a single cycle on this cycle's flags.
                  if (!branch_taken(kind, ir, status, reg_zero)) begin
                     PS    <= PS_INC;
                     PC_IN <= '0;
                  end else if (kind == K_BR) begin
                     PS    <= PS_LOAD;
                     PC_IN <= OFFSET_W'(reg_data);
                  end else begin
                     PS    <= PS_ADD;
                     PC_IN <= branch_offset(kind, ir);
                  end
                  state <= S_UPDATE;
               end
            end
            S_UPDATE: begin
               PS       <= PS_HOLD;
               PC_IN    <= '0;
               imem_req <= 1'b1;
               wait_cnt <= '0;
               state    <= S_FETCH;
            end
            S_HALT: begin
               state <= S_HALT;
            end
            S_FAULT: begin
               state <= S_FAULT;
            end
            default: begin
               state <= S_FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        imem_req;
   logic        imem_ack = 1'b0;
   logic [31:0] instr = '0;
   logic [3:0]  status = '0;
   logic        reg_zero = 1'b0;
   logic [31:0] reg_data = '0;
   logic        exec_done = 1'b0;
   logic        exec_en;
   logic [31:0] ir;
   logic [1:0]  PS;
   logic [31:0] PC_IN;
   logic        halted;
   logic        fault;

   int n_checks = 0;
   int n_fail   = 0;

   pc_sequencer #(.WAIT_LIMIT(16), .OFFSET_W(32)) dut (
      .clock(clock), .reset(reset), .imem_req(imem_req), .imem_ack(imem_ack),
      .instr(instr), .status(status), .reg_zero(reg_zero), .reg_data(reg_data),
      .exec_done(exec_done), .exec_en(exec_en), .ir(ir), .PS(PS), .PC_IN(PC_IN),
      .halted(halted), .fault(fault)
   );

   always #5 clock = ~clock;

   // Single comparison point: counts and reports.
   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Wait (bounded) for a request, hand over one word, and step into EXEC/HALT.
   task automatic fetch(input logic [31:0] word);
      int n;
      n = 0;
      while (!imem_req && n < 40) begin
         tick();
         n++;
      end
      check_eq("fetch_req", {63'd0, imem_req}, 64'd1);
      imem_ack = 1'b1;
      instr    = word;
      tick();
      imem_ack = 1'b0;
      check_eq("ir_latch", {32'd0, ir}, {32'd0, word});
      check_eq("req_drop", {63'd0, imem_req}, 64'd0);
      tick();
   endtask

   // One branch instruction: inputs set up before EXEC, PS/PC_IN checked in UPDATE.
   task automatic branch(input string tag, input logic [31:0] word, input logic [3:0] st,
                         input logic rz, input logic [31:0] rd,
                         input logic [1:0] exp_ps, input logic [31:0] exp_pc);
      status   = st;
      reg_zero = rz;
      reg_data = rd;
      fetch(word);
      check_eq({tag, "_exec_en"}, {63'd0, exec_en}, 64'd0);
      check_eq({tag, "_ps_exec"}, {62'd0, PS}, 64'd0);
      tick();
      check_eq({tag, "_ps"}, {62'd0, PS}, {62'd0, exp_ps});
      check_eq({tag, "_pc_in"}, {32'd0, PC_IN}, {32'd0, exp_pc});
      tick();
      check_eq({tag, "_ps_after"}, {62'd0, PS}, 64'd0);
      check_eq({tag, "_req_after"}, {63'd0, imem_req}, 64'd1);
   endtask

   initial begin
      int n;

      // Reset held low for two edges with ack asserted.
      reset    = 1'b0;
      imem_ack = 1'b1;
      tick();
      tick();
      check_eq("rst_req", {63'd0, imem_req}, 64'd0);
      check_eq("rst_exec_en", {63'd0, exec_en}, 64'd0);
      check_eq("rst_ps", {62'd0, PS}, 64'd0);
      check_eq("rst_pc_in", {32'd0, PC_IN}, 64'd0);
      check_eq("rst_ir", {32'd0, ir}, 64'd0);
      check_eq("rst_halted", {63'd0, halted}, 64'd0);
      check_eq("rst_fault", {63'd0, fault}, 64'd0);
      reset    = 1'b1;
      imem_ack = 1'b0;
      tick();
      check_eq("rel_req", {63'd0, imem_req}, 64'd1);
      check_eq("rel_ps", {62'd0, PS}, 64'd0);

      // ALU op, exec_done on the third EXEC cycle.
      fetch(32'h8B02_0020);
      for (int i = 0; i < 3; i++) begin
         check_eq("alu_exec_en", {63'd0, exec_en}, 64'd1);
         check_eq("alu_ps_exec", {62'd0, PS}, 64'd0);
         if (i == 2) exec_done = 1'b1;
         tick();
      end
      exec_done = 1'b0;
      check_eq("alu_exec_en_upd", {63'd0, exec_en}, 64'd0);
      check_eq("alu_ps", {62'd0, PS}, 64'd1);
      check_eq("alu_pc_in", {32'd0, PC_IN}, 64'd0);
      tick();
      check_eq("alu_req_after", {63'd0, imem_req}, 64'd1);
      check_eq("alu_ps_after", {62'd0, PS}, 64'd0);

      // Branch vectors.
      branch("beq_t",  32'h54FF_FF80, 4'b0100, 1'b0, 32'd0, 2'b11, 32'hFFFF_FFFC);
      branch("beq_nt", 32'h54FF_FF80, 4'b0000, 1'b0, 32'd0, 2'b01, 32'd0);
      branch("cbnz_t", 32'hB500_0100, 4'b0000, 1'b0, 32'd0, 2'b11, 32'd8);
      branch("cbnz_n", 32'hB500_0100, 4'b0000, 1'b1, 32'd0, 2'b01, 32'd0);
      branch("cbz_t",  32'hB400_0100, 4'b0000, 1'b1, 32'd0, 2'b11, 32'd8);
      branch("br",     32'hD61F_0000, 4'b0000, 1'b0, 32'd5, 2'b10, 32'd5);
      branch("gt_nt",  32'h5400_008C, 4'b1000, 1'b0, 32'd0, 2'b01, 32'd0);
      branch("ge_t",   32'h5400_008A, 4'b1001, 1'b0, 32'd0, 2'b11, 32'd4);
      branch("hi_t",   32'h5400_0088, 4'b0010, 1'b0, 32'd0, 2'b11, 32'd4);
      branch("b_neg",  32'h17FF_FFFE, 4'b0000, 1'b0, 32'd0, 2'b11, 32'hFFFF_FFFE);

      // Reset in the middle of an ALU EXEC.
      fetch(32'h8B02_0020);
      tick();
      check_eq("mid_exec_en", {63'd0, exec_en}, 64'd1);
      reset = 1'b0;
      tick();
      check_eq("mid_rst_exec_en", {63'd0, exec_en}, 64'd0);
      check_eq("mid_rst_req", {63'd0, imem_req}, 64'd0);
      check_eq("mid_rst_halted", {63'd0, halted}, 64'd0);
      reset = 1'b1;
      tick();
      check_eq("mid_rel_req", {63'd0, imem_req}, 64'd1);

      // HALT is sticky and ignores acks.
      fetch(32'hFFFF_FFFF);
      imem_ack = 1'b1;
      for (int i = 0; i < 22; i++) begin
         check_eq("halt_halted", {63'd0, halted}, 64'd1);
         check_eq("halt_ps", {62'd0, PS}, 64'd0);
         check_eq("halt_req", {63'd0, imem_req}, 64'd0);
         tick();
      end
      imem_ack = 1'b0;
      reset = 1'b0;
      tick();
      check_eq("halt_rst", {63'd0, halted}, 64'd0);
      reset = 1'b1;
      tick();

      // No ack ever: fault after 16 requesting FETCH cycles.
      n = 0;
      while (!fault && n < 40) begin
         check_eq("wait_ps", {62'd0, PS}, 64'd0);
         tick();
         n++;
      end
      check_eq("fault_cycles", 64'(n), 64'd16);
      check_eq("fault_flag", {63'd0, fault}, 64'd1);
      imem_ack = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check_eq("fault_req", {63'd0, imem_req}, 64'd0);
         check_eq("fault_ps", {62'd0, PS}, 64'd0);
         check_eq("fault_sticky", {63'd0, fault}, 64'd1);
         tick();
      end
      reset = 1'b0;
      tick();
      check_eq("fault_rst", {63'd0, fault}, 64'd0);
      imem_ack = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
